// File: rtl/uart_pkg.sv
// Shared constants for the UART transmit path: line timing and sequencer state encoding.
package uart_pkg;

  localparam int unsigned CLK_FREQ   = 50_000_000;
  localparam int unsigned BAUD_RATE  = 9600;
  localparam int unsigned BIT_PERIOD = CLK_FREQ / BAUD_RATE;

  localparam int unsigned STATE_W = 3;
  typedef logic [STATE_W-1:0] state_t;

  localparam state_t ST_IDLE      = 3'd0;
  localparam state_t ST_LOAD      = 3'd1;
  localparam state_t ST_SEND      = 3'd2;
  localparam state_t ST_WAIT_BUSY = 3'd3;
  localparam state_t ST_WAIT_DONE = 3'd4;

endpackage

// File: rtl/uart_sync_fifo.sv
// Single-clock FIFO with registered occupancy, full and empty; head entry is read combinationally.
module uart_sync_fifo #(
  parameter int unsigned DEPTH = 16,
  parameter int unsigned WIDTH = 8
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    push,
  input  logic                    pop,
  input  logic [WIDTH-1:0]        wr_data,
  output logic [WIDTH-1:0]        rd_data_c,
  output logic                    full,
  output logic                    empty,
  output logic [$clog2(DEPTH):0]  count,
  output logic                    empty_nxt_c
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [CW-1:0]    count_nxt;
  logic             push_ok;
  logic             pop_ok;

  // Space is judged on the registered full flag, so a same-cycle pop never admits a write.
  assign push_ok     = push && !full;
  assign pop_ok      = pop && !empty;
  assign rd_data_c   = mem[rd_ptr];
  assign empty_nxt_c = (count_nxt == '0);

  always_comb begin
    count_nxt = count;
    if (push_ok && !pop_ok) begin
      count_nxt = count + CW'(1);
    end else if (!push_ok && pop_ok) begin
      count_nxt = count - CW'(1);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      full   <= 1'b0;
      empty  <= 1'b1;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + AW'(1);
      if (pop_ok)  rd_ptr <= rd_ptr + AW'(1);
      count <= count_nxt;
      full  <= (count_nxt == CW'(DEPTH));
      empty <= (count_nxt == '0);
    end
  end

  // Storage is not reset; stale entries are unreachable once the pointers are zeroed.
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= wr_data;
  end

endmodule

// File: rtl/uart_tx_fifo.sv
// Byte FIFO plus send sequencer feeding uart_tx through its send/data_in/ready handshake.
module uart_tx_fifo
  import uart_pkg::*;
#(
  parameter int unsigned DEPTH       = 16,
  parameter int unsigned ACK_TIMEOUT = 16
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    wr_en,
  input  logic [7:0]              wr_data,
  output logic                    full,
  output logic                    empty,
  output logic [$clog2(DEPTH):0]  count,
  output logic                    overflow,
  output logic                    tx_err,
  input  logic                    clr_flags,
  output logic                    tx_send,
  output logic [7:0]              tx_data,
  input  logic                    tx_ready,
  output logic                    busy
);

  localparam int unsigned TW = $clog2(ACK_TIMEOUT + 1);

  state_t        state_q;
  state_t        state_nxt;
  logic [TW-1:0] timer_q;
  logic [7:0]    head_c;
  logic          empty_nxt_c;
  logic          latch_c;
  logic          pop_c;
  logic          timeout_c;
  logic          busy_nxt_c;

  uart_sync_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (8)
  ) u_fifo (
    .clk         (clk),
    .reset_n     (reset_n),
    .push        (wr_en),
    .pop         (pop_c),
    .wr_data     (wr_data),
    .rd_data_c   (head_c),
    .full        (full),
    .empty       (empty),
    .count       (count),
    .empty_nxt_c (empty_nxt_c)
  );

  // uart_tx never acknowledged the send: still ready after the allowed window.
  assign timeout_c = (state_q == ST_WAIT_BUSY) && tx_ready &&
                     (timer_q == TW'(ACK_TIMEOUT - 1));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= ST_IDLE;
    else          state_q <= state_nxt;
  end

  always_comb begin
    state_nxt = state_q;
    case (state_q)
      ST_IDLE:      if (!empty && tx_ready) state_nxt = ST_LOAD;
      ST_LOAD:      state_nxt = ST_SEND;
      ST_SEND:      state_nxt = ST_WAIT_BUSY;
      ST_WAIT_BUSY: begin
        if (!tx_ready)      state_nxt = ST_WAIT_DONE;
        else if (timeout_c) state_nxt = ST_IDLE;
      end
      ST_WAIT_DONE: if (tx_ready) state_nxt = ST_IDLE;
      default:      state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    latch_c    = 1'b0;
    pop_c      = 1'b0;
    busy_nxt_c = 1'b0;
    latch_c    = (state_q == ST_IDLE) && !empty && tx_ready;
    pop_c      = (state_q == ST_LOAD);
    busy_nxt_c = (state_nxt != ST_IDLE) || !empty_nxt_c;
  end

  // Registered outputs, ack timer and sticky flags (a set event beats clr_flags).
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      tx_send  <= 1'b0;
      tx_data  <= 8'h00;
      timer_q  <= '0;
      overflow <= 1'b0;
      tx_err   <= 1'b0;
      busy     <= 1'b0;
    end else begin
      tx_send <= pop_c;
      if (latch_c) tx_data <= head_c;
      if (state_q == ST_SEND) begin
        timer_q <= '0;
      end else if ((state_q == ST_WAIT_BUSY) && (timer_q != TW'(ACK_TIMEOUT))) begin
        timer_q <= timer_q + TW'(1);
      end
      if (wr_en && full)  overflow <= 1'b1;
      else if (clr_flags) overflow <= 1'b0;
      if (timeout_c)      tx_err <= 1'b1;
      else if (clr_flags) tx_err <= 1'b0;
      busy <= busy_nxt_c;
    end
  end

endmodule
